// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU: hazard FSM states and
// register-file constants used by the hazard controller.
package cpu_pkg;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         MAX_FLUSH = 4;
  // Wide enough to hold MAX_FLUSH itself.
  localparam int         REM_W     = $clog2(MAX_FLUSH) + 1;

endpackage

// File: rtl/id_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard debug event counters;
// it sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: clear on reset, step on inc until all-ones.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, taken-branch flushes and
// whole-pipe freeze on data-memory wait, with debug event counters.
module id_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic             EX_RegWriteEN,
  input  logic [4:0]       EX_DstReg,
  input  logic             EX_Beq,
  input  logic             EX_Bne,
  input  logic             EX_Zero,
  input  logic             MEM_Wait,
  output logic             PCWriteEN,
  output logic             PCSrcSEL,
  output logic             IFIDWriteEN,
  output logic             IFIDFlush,
  output logic             CtrlBubble,
  output logic             PipeHold,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [REM_W-1:0] FLUSH_INIT = REM_W'(FLUSH_CYCLES - 1);

  hz_state_t        state, state_next;
  logic [REM_W-1:0] remaining, rem_next;
  logic             taken, lu, stall_inc, flush_inc;

  assign taken = (EX_Beq & EX_Zero) | (EX_Bne & ~EX_Zero);
  assign lu    = EX_MemRead & EX_RegWriteEN & (EX_DstReg != REG_ZERO) &
                 ((EX_DstReg == ID_Rs) | (ID_UsesRt & (EX_DstReg == ID_Rt)));

  // FSM state and remaining-bubble register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_RUN;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= rem_next;
    end
  end

  // Mealy outputs and next state; MEM_Wait freezes everything, including remaining.
  always_comb begin
    PCWriteEN   = 1'b1;
    PCSrcSEL    = 1'b0;
    IFIDWriteEN = 1'b1;
    IFIDFlush   = 1'b0;
    CtrlBubble  = 1'b0;
    PipeHold    = 1'b0;
    state_next  = state;
    rem_next    = remaining;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (RESET) begin
      PCWriteEN   = 1'b0;
      IFIDWriteEN = 1'b0;
      IFIDFlush   = 1'b1;
      CtrlBubble  = 1'b1;
      state_next  = S_RUN;
      rem_next    = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (MEM_Wait) begin
            PCWriteEN   = 1'b0;
            IFIDWriteEN = 1'b0;
            PipeHold    = 1'b1;
          end else if (taken) begin
            PCSrcSEL   = 1'b1;
            IFIDFlush  = 1'b1;
            CtrlBubble = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = S_FLUSH;
              rem_next   = FLUSH_INIT;
            end else begin
              state_next = S_RUN;
            end
          end else if (lu) begin
            PCWriteEN   = 1'b0;
            IFIDWriteEN = 1'b0;
            CtrlBubble  = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            state_next = S_RUN;
          end
        end
        S_FLUSH: begin
          if (MEM_Wait) begin
            PCWriteEN   = 1'b0;
            IFIDWriteEN = 1'b0;
            PipeHold    = 1'b1;
          end else begin
            IFIDFlush  = 1'b1;
            CtrlBubble = 1'b1;
            if (remaining <= REM_W'(1)) begin
              state_next = S_RUN;
              rem_next   = '0;
            end else begin
              state_next = S_FLUSH;
              rem_next   = remaining - REM_W'(1);
            end
          end
        end
        default: begin
          state_next = S_RUN;
          rem_next   = '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (stall_inc),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (flush_inc),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed scoreboard bench for id_hazard_ctrl: one instance with
// FLUSH_CYCLES=2/CNT_W=16, one with FLUSH_CYCLES=4/CNT_W=4.
module tb_id_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic       reg_write;
    logic [4:0] dst;
    logic       beq;
    logic       bne;
    logic       zero;
    logic       mem_wait;
  } stim_t;

  typedef struct {
    string       tag;
    logic [5:0]  outs;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  // {PCWriteEN, PCSrcSEL, IFIDWriteEN, IFIDFlush, CtrlBubble, PipeHold}
  localparam logic [5:0] O_DEF  = 6'b101000;
  localparam logic [5:0] O_HOLD = 6'b000001;
  localparam logic [5:0] O_TAKE = 6'b111110;
  localparam logic [5:0] O_LU   = 6'b000010;
  localparam logic [5:0] O_FL   = 6'b101110;
  localparam logic [5:0] O_RST  = 6'b000110;

  logic  clk = 1'b0;
  stim_t ia, ib;
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  logic        pcw_a, pcs_a, ifw_a, iff_a, cb_a, ph_a;
  logic        pcw_b, pcs_b, ifw_b, iff_b, cb_b, ph_b;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .CLK(clk), .RESET(ia.rst), .ID_Rs(ia.rs), .ID_Rt(ia.rt), .ID_UsesRt(ia.uses_rt),
    .EX_MemRead(ia.mem_read), .EX_RegWriteEN(ia.reg_write), .EX_DstReg(ia.dst),
    .EX_Beq(ia.beq), .EX_Bne(ia.bne), .EX_Zero(ia.zero), .MEM_Wait(ia.mem_wait),
    .PCWriteEN(pcw_a), .PCSrcSEL(pcs_a), .IFIDWriteEN(ifw_a), .IFIDFlush(iff_a),
    .CtrlBubble(cb_a), .PipeHold(ph_a), .StallCnt(stall_a), .FlushCnt(flush_a)
  );

  id_hazard_ctrl #(.FLUSH_CYCLES(4), .CNT_W(4)) dut_b (
    .CLK(clk), .RESET(ib.rst), .ID_Rs(ib.rs), .ID_Rt(ib.rt), .ID_UsesRt(ib.uses_rt),
    .EX_MemRead(ib.mem_read), .EX_RegWriteEN(ib.reg_write), .EX_DstReg(ib.dst),
    .EX_Beq(ib.beq), .EX_Bne(ib.bne), .EX_Zero(ib.zero), .MEM_Wait(ib.mem_wait),
    .PCWriteEN(pcw_b), .PCSrcSEL(pcs_b), .IFIDWriteEN(ifw_b), .IFIDFlush(iff_b),
    .CtrlBubble(cb_b), .PipeHold(ph_b), .StallCnt(stall_b), .FlushCnt(flush_b)
  );

  function automatic stim_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses, input logic mr, input logic rw,
                               input logic [4:0] dst, input logic beq, input logic bne,
                               input logic zero, input logic mw);
    stim_t s;
    s.rst = rst; s.rs = rs; s.rt = rt; s.uses_rt = uses; s.mem_read = mr;
    s.reg_write = rw; s.dst = dst; s.beq = beq; s.bne = bne; s.zero = zero;
    s.mem_wait = mw;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t rst_in();
    return mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Load in EX writing dst while ID reads rs/rt.
  function automatic stim_t lu_in(input logic [4:0] dst, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic uses);
    return mk(1'b0, rs, rt, uses, 1'b1, 1'b1, dst, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t br_in(input logic beq, input logic bne, input logic zero);
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, beq, bne, zero, 1'b0);
  endfunction

  // Drive one cycle, queue its expectation, then pop and compare mid-cycle.
  task automatic step(input bit sel, input stim_t s, input logic [5:0] eo,
                      input int es, input int ef, input string tag);
    exp_t        e;
    exp_t        got;
    logic [5:0]  obs;
    logic [15:0] os, of;
    if (sel) ib = s; else ia = s;
    e.tag = tag; e.outs = eo; e.stall = 16'(es); e.flush = 16'(ef);
    sb.push_back(e);
    #5;
    got = sb.pop_front();
    obs = sel ? {pcw_b, pcs_b, ifw_b, iff_b, cb_b, ph_b}
              : {pcw_a, pcs_a, ifw_a, iff_a, cb_a, ph_a};
    os  = sel ? {12'd0, stall_b} : stall_a;
    of  = sel ? {12'd0, flush_b} : flush_a;
    checks += 3;
    assert (obs === got.outs) else begin
      errors++;
      $error("FAIL %s outs observed=%b expected=%b", got.tag, obs, got.outs);
    end
    assert (os === got.stall) else begin
      errors++;
      $error("FAIL %s StallCnt observed=%0d expected=%0d", got.tag, os, got.stall);
    end
    assert (of === got.flush) else begin
      errors++;
      $error("FAIL %s FlushCnt observed=%0d expected=%0d", got.tag, of, got.flush);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ia = rst_in();
    ib = rst_in();
    @(posedge clk);
    #1;

    step(1'b0, rst_in(), O_RST, 0, 0, "a_reset");
    step(1'b0, idle(), O_DEF, 0, 0, "a_idle");
    step(1'b0, lu_in(5'd8, 5'd8, 5'd0, 1'b0), O_LU, 0, 0, "a_lu_rs");
    step(1'b0, idle(), O_DEF, 1, 0, "a_lu_done");
    step(1'b0, lu_in(5'd0, 5'd0, 5'd0, 1'b1), O_DEF, 1, 0, "a_lu_r0");
    step(1'b0, lu_in(5'd9, 5'd3, 5'd9, 1'b1), O_LU, 1, 0, "a_lu_rt");
    step(1'b0, lu_in(5'd9, 5'd3, 5'd9, 1'b0), O_DEF, 2, 0, "a_rt_unused");
    step(1'b0, br_in(1'b1, 1'b0, 1'b1), O_TAKE, 2, 0, "a_beq_c0");
    step(1'b0, idle(), O_FL, 2, 1, "a_beq_c1");
    step(1'b0, idle(), O_DEF, 2, 1, "a_beq_c2");
    step(1'b0, br_in(1'b0, 1'b1, 1'b1), O_DEF, 2, 1, "a_bne_not_taken");
    step(1'b0, mk(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0),
         O_TAKE, 2, 1, "a_br_and_lu");
    step(1'b0, idle(), O_FL, 2, 2, "a_br_and_lu_c1");
    step(1'b0, idle(), O_DEF, 2, 2, "a_br_and_lu_c2");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, mk(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1),
           O_HOLD, 2, 2, "a_wait_lu");
    end
    step(1'b0, lu_in(5'd8, 5'd8, 5'd0, 1'b0), O_LU, 2, 2, "a_lu_after_wait");
    step(1'b0, idle(), O_DEF, 3, 2, "a_after_wait_lu");
    step(1'b0, br_in(1'b1, 1'b0, 1'b1), O_TAKE, 3, 2, "a_beq2_c0");
    step(1'b0, mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1),
         O_HOLD, 3, 3, "a_wait_in_flush");
    step(1'b0, idle(), O_FL, 3, 3, "a_flush_resumed");
    step(1'b0, idle(), O_DEF, 3, 3, "a_flush_done");
    step(1'b0, mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1),
         O_HOLD, 3, 3, "a_wait_bne");
    step(1'b0, br_in(1'b0, 1'b1, 1'b0), O_TAKE, 3, 3, "a_bne_taken");
    step(1'b0, idle(), O_FL, 3, 4, "a_bne_c1");
    step(1'b0, idle(), O_DEF, 3, 4, "a_bne_c2");

    step(1'b1, rst_in(), O_RST, 0, 0, "b_reset");
    step(1'b1, br_in(1'b1, 1'b0, 1'b1), O_TAKE, 0, 0, "b_beq_c0");
    step(1'b1, idle(), O_FL, 0, 1, "b_beq_c1");
    step(1'b1, rst_in(), O_RST, 0, 1, "b_reset_in_flush");
    step(1'b1, idle(), O_DEF, 0, 0, "b_after_reset");
    step(1'b1, idle(), O_DEF, 0, 0, "b_after_reset2");
    step(1'b1, br_in(1'b1, 1'b0, 1'b1), O_TAKE, 0, 0, "b_full_c0");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, idle(), O_FL, 0, 1, "b_full_bubble");
    end
    step(1'b1, idle(), O_DEF, 0, 1, "b_full_done");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, lu_in(5'd5, 5'd5, 5'd0, 1'b0), O_LU, (i > 15) ? 15 : i, 1, "b_sat_lu");
      step(1'b1, idle(), O_DEF, (i + 1 > 15) ? 15 : i + 1, 1, "b_sat_idle");
    end
    step(1'b1, idle(), O_DEF, 15, 1, "b_sat_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
